// File: rtl/frame_swap_ctrl.sv
// Ping-pong frame buffer sequencer: clears the back buffer, grants the renderer,
// then swaps buffers during vblank while counting presented and dropped frames.
module frame_swap_ctrl #(
  parameter int unsigned        A         = 9,
  parameter int unsigned        S         = 24,
  parameter logic [S-1:0]       CLEAR_VAL = '0,
  parameter int unsigned        CW        = 16
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          frame_done,
  input  logic          vblank,
  input  logic [A-1:0]  r_addr,
  input  logic [S-1:0]  r_data,
  input  logic          r_wren,
  output logic          render_en,
  output logic [A-1:0]  mem_addr,
  output logic [S-1:0]  mem_data,
  output logic          mem_wren,
  output logic          swap,
  output logic          busy_clear,
  output logic [CW-1:0] frame_count,
  output logic [CW-1:0] drop_count
);

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    RENDER  = 2'd1,
    WAIT_VB = 2'd2,
    SWAP    = 2'd3
  } state_t;

  state_t         state;
  logic [A-1:0]   clr_addr;
  logic           vblank_q;
  logic           vb_rise;
  logic           drop_ok;

  assign vb_rise = vblank & ~vblank_q;
  assign drop_ok = (state == CLEAR) || (state == RENDER);

  always_comb begin
    mem_addr = clr_addr;
    mem_data = CLEAR_VAL;
    mem_wren = 1'b0;
    unique case (state)
      CLEAR: begin
        mem_wren = 1'b1;
      end
      RENDER: begin
        mem_addr = r_addr;
        mem_data = r_data;
        mem_wren = r_wren;
      end
      default: begin
        mem_wren = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= CLEAR;
      clr_addr    <= '0;
      swap        <= 1'b0;
      render_en   <= 1'b0;
      busy_clear  <= 1'b1;
      frame_count <= '0;
      drop_count  <= '0;
      vblank_q    <= 1'b0;
    end else begin
      vblank_q <= vblank;
      // Edges seen in WAIT_VB belong to the swap itself, not a drop.
      if (vb_rise && drop_ok && (drop_count != {CW{1'b1}}))
        drop_count <= drop_count + 1'b1;

      unique case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == {A{1'b1}}) begin
            state      <= RENDER;
            render_en  <= 1'b1;
            busy_clear <= 1'b0;
          end
        end
        RENDER: begin
          if (frame_done) begin
            state     <= WAIT_VB;
            render_en <= 1'b0;
          end
        end
        WAIT_VB: begin
          if (vblank) begin
            state       <= SWAP;
            swap        <= 1'b1;
            frame_count <= frame_count + 1'b1;
          end
        end
        SWAP: begin
          state      <= CLEAR;
          swap       <= 1'b0;
          busy_clear <= 1'b1;
          clr_addr   <= '0;
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Directed bench for frame_swap_ctrl: clear sweep, render passthrough,
// vblank-gated swap, drop counting and mid-clear reset.
module tb_frame_swap_ctrl;

  localparam int A  = 4;
  localparam int S  = 24;
  localparam int CW = 16;
  localparam logic [S-1:0] CV = 24'hABCDEF;

  logic          clock = 1'b0;
  logic          resetn;
  logic          frame_done;
  logic          vblank;
  logic [A-1:0]  r_addr;
  logic [S-1:0]  r_data;
  logic          r_wren;
  logic          render_en;
  logic [A-1:0]  mem_addr;
  logic [S-1:0]  mem_data;
  logic          mem_wren;
  logic          swap;
  logic          busy_clear;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] drop_count;

  int tests = 0;
  int fails = 0;

  frame_swap_ctrl #(.A(A), .S(S), .CLEAR_VAL(CV), .CW(CW)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .frame_done  (frame_done),
    .vblank      (vblank),
    .r_addr      (r_addr),
    .r_data      (r_data),
    .r_wren      (r_wren),
    .render_en   (render_en),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .swap        (swap),
    .busy_clear  (busy_clear),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  // Called just after the edge that puts the clear engine at address 0.
  task automatic run_clear();
    for (int i = 0; i < 16; i++) begin
      settle();
      chk("clr_addr", 32'(mem_addr), 32'(i));
      chk("clr_data", 32'(mem_data), 32'(CV));
      chk("clr_wren", 32'(mem_wren), 32'd1);
      chk("clr_busy", 32'(busy_clear), 32'd1);
      chk("clr_ren", 32'(render_en), 32'd0);
      step();
    end
    settle();
    chk("post_clr_ren", 32'(render_en), 32'd1);
    chk("post_clr_busy", 32'(busy_clear), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    frame_done = 1'b0;
    vblank = 1'b0;
    r_addr = '0;
    r_data = '0;
    r_wren = 1'b0;
    repeat (3) step();
    settle();
    chk("rst_swap", 32'(swap), 32'd0);
    chk("rst_ren", 32'(render_en), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_dc", 32'(drop_count), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);

    // 1: first clear after reset release
    step();
    resetn = 1'b1;
    run_clear();

    // 2: renderer passthrough, same-cycle and with frame_done
    step();
    r_addr = 4'd5;
    r_data = 24'h123456;
    r_wren = 1'b1;
    settle();
    chk("rd_addr", 32'(mem_addr), 32'd5);
    chk("rd_data", 32'(mem_data), 32'h123456);
    chk("rd_wren", 32'(mem_wren), 32'd1);
    step();
    frame_done = 1'b1;
    settle();
    chk("fd_wren", 32'(mem_wren), 32'd1);
    chk("fd_addr", 32'(mem_addr), 32'd5);
    step();
    frame_done = 1'b0;
    settle();
    chk("wvb_wren", 32'(mem_wren), 32'd0);
    chk("wvb_ren", 32'(render_en), 32'd0);

    // 3: swap waits for vblank
    for (int k = 0; k < 10; k++) begin
      step();
      settle();
      chk("wvb_noswap", 32'(swap), 32'd0);
    end
    step();
    r_wren = 1'b0;
    vblank = 1'b1;
    settle();
    chk("vb_pre_swap", 32'(swap), 32'd0);
    step();
    settle();
    chk("swap1", 32'(swap), 32'd1);
    chk("fc1", 32'(frame_count), 32'd1);
    step();
    vblank = 1'b0;
    #1;
    chk("swap1_end", 32'(swap), 32'd0);
    chk("dc_after_swap", 32'(drop_count), 32'd0);
    run_clear();

    // 4: three dropped vblanks while rendering
    for (int k = 0; k < 3; k++) begin
      step();
      vblank = 1'b1;
      step();
      vblank = 1'b0;
    end
    step();
    settle();
    chk("dc3", 32'(drop_count), 32'd3);
    chk("drop_noswap", 32'(swap), 32'd0);
    chk("drop_ren", 32'(render_en), 32'd1);

    // 5b: frame_done together with a vblank rising edge
    step();
    vblank = 1'b1;
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    settle();
    chk("sim_dc4", 32'(drop_count), 32'd4);
    chk("sim_noswap", 32'(swap), 32'd0);
    chk("sim_ren", 32'(render_en), 32'd0);
    step();
    settle();
    chk("sim_swap", 32'(swap), 32'd1);
    chk("fc2", 32'(frame_count), 32'd2);
    step();
    #1;
    chk("sim_swap_end", 32'(swap), 32'd0);
    run_clear();

    // 5a: vblank already high, swap two cycles after frame_done
    step();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    settle();
    chk("lat_noswap", 32'(swap), 32'd0);
    step();
    settle();
    chk("lat_swap", 32'(swap), 32'd1);
    chk("fc3", 32'(frame_count), 32'd3);
    chk("lat_dc", 32'(drop_count), 32'd4);
    step();
    vblank = 1'b0;
    #1;
    chk("lat_swap_end", 32'(swap), 32'd0);

    // 6: async reset in the middle of a clear
    repeat (7) step();
    settle();
    chk("pre_rst_addr", 32'(mem_addr), 32'd7);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_addr", 32'(mem_addr), 32'd0);
    chk("ar_fc", 32'(frame_count), 32'd0);
    chk("ar_dc", 32'(drop_count), 32'd0);
    chk("ar_swap", 32'(swap), 32'd0);
    chk("ar_ren", 32'(render_en), 32'd0);
    chk("ar_busy", 32'(busy_clear), 32'd1);
    step();
    step();
    resetn = 1'b1;
    frame_done = 1'b1;
    run_clear();
    frame_done = 1'b0;
    step();
    settle();
    chk("fd_ignored_in_clear", 32'(render_en), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
